// File: rtl/data_mem_resp.sv
// data_mem_resp: single-port word memory behind a req/gnt/rvalid data
// interface with a configurable number of wait cycles before each grant.
//
// Parameters
//   DEPTH        number of 32-bit words (power of two, 16..65536)
//   WAIT_CYCLES  cycles a request waits before it is granted (0..7)
//
// Ports
//   clk_i, rst_ni        clock (rising edge) / async active-low reset
//   data_req_i           initiator request, fields held until granted
//   data_gnt_o           combinational grant; the access happens on this edge
//   data_rvalid_o        one-cycle response, the cycle after each grant
//   data_addr_i          byte address, word index = addr[AW+1:2]
//   data_we_i            1 = write, 0 = read
//   data_be_i            byte enables for writes
//   data_wdata_i         write data
//   data_rdata_o         read data (0 for writes/errors), held between responses
//   data_err_o           error response flag
//
// Optional feature: define DATA_MEM_RESP_ERR_EN to flag addresses whose bits
// above the memory range are nonzero (no write, rdata 0, err 1). Without it
// those bits are ignored and the address wraps modulo DEPTH words.
module data_mem_resp #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam bit          NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [2:0]  CNT_LOAD = 3'(NO_WAIT ? 0 : WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        gnt;
  logic        addr_err;
  logic        unused_bits;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH];

  assign idx = data_addr_i[AW+1:2];

`ifdef DATA_MEM_RESP_ERR_EN
  assign addr_err    = |data_addr_i[31:AW+2];
  assign unused_bits = ^data_addr_i[1:0];
`else
  assign addr_err    = 1'b0;
  assign unused_bits = ^{data_addr_i[31:AW+2], data_addr_i[1:0]};
`endif

  // A request seen in IDLE or RESP either is granted at once (no wait
  // configured) or starts the wait countdown; the grant comes at cnt == 0.
  always_comb begin
    gnt     = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_RESP: begin
        if (data_req_i) begin
          if (NO_WAIT) begin
            gnt     = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!data_req_i) begin
          // initiator withdrew the request: abandon it, no access
          cnt_d   = 3'd0;
          state_d = S_IDLE;
        end else if (cnt_q == 3'd0) begin
          gnt     = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q - 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Gate with reset so the grant is low while reset is asserted even if a
  // zero-wait request is present in IDLE.
  assign data_gnt_o = gnt & rst_ni;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      cnt_q         <= 3'd0;
      data_rvalid_o <= 1'b0;
      data_rdata_o  <= 32'd0;
      data_err_o    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      data_rvalid_o <= gnt;
      if (gnt) begin
        data_err_o   <= addr_err;
        // read sees the pre-edge contents; writes respond with zero
        data_rdata_o <= (data_we_i || addr_err) ? 32'd0 : mem[idx];
      end
    end
  end

  // Memory array is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (data_gnt_o && data_we_i && !addr_err) begin
      for (int k = 0; k < 4; k++) begin
        if (data_be_i[k]) mem[idx][8*k +: 8] <= data_wdata_i[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: two instances (no wait / three wait cycles) driven
// by directed sequences and random bursts, checked against a word-level
// memory model held in an associative array.
module tb_data_mem_resp;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req[2], gnt[2], rvalid[2], we[2], err[2];
  logic [31:0] addr[2], wdata[2], rdata[2];
  logic [3:0]  be[2];

  int checks = 0;
  int errors = 0;
  logic [31:0] mm [int];  // expected memory contents, keyed by instance+word

  always #5 clk = ~clk;

  data_mem_resp #(.DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[0]), .data_gnt_o(gnt[0]),
    .data_rvalid_o(rvalid[0]), .data_addr_i(addr[0]), .data_we_i(we[0]),
    .data_be_i(be[0]), .data_wdata_i(wdata[0]), .data_rdata_o(rdata[0]),
    .data_err_o(err[0]));

  data_mem_resp #(.DEPTH(1024), .WAIT_CYCLES(3)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[1]), .data_gnt_o(gnt[1]),
    .data_rvalid_o(rvalid[1]), .data_addr_i(addr[1]), .data_we_i(we[1]),
    .data_be_i(be[1]), .data_wdata_i(wdata[1]), .data_rdata_o(rdata[1]),
    .data_err_o(err[1]));

  function automatic int wc(int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic op_t mk(logic w, logic [31:0] a, logic [3:0] b, logic [31:0] v);
    op_t o;
    o.we = w; o.addr = a; o.be = b; o.wdata = v;
    return o;
  endfunction

  function automatic bit m_err(logic [31:0] a);
`ifdef DATA_MEM_RESP_ERR_EN
    return (a / 32'd4096) != 0;
`else
    return (a != a);
`endif
  endfunction

  function automatic int m_key(int d, logic [31:0] a);
    return d * 4096 + int'((a / 4) % 1024);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue ops back to back on instance d (req held between them), checking
  // grant latency and each response against the model.
  task automatic run(int d, input op_t ops[$]);
    int n;
    int key;
    bit known;
    logic ee;
    logic [31:0] er, cur;
    known = 0;
    er = 0;
    foreach (ops[i]) begin
      req[d] = 1; we[d] = ops[i].we; addr[d] = ops[i].addr;
      be[d] = ops[i].be; wdata[d] = ops[i].wdata;
      n = 0;
      forever begin
        @(negedge clk);
        if (gnt[d]) break;
        n++;
        if (n > 20) break;
        @(posedge clk); #1;
      end
      chk($sformatf("d%0d_op%0d_latency", d, i), n, wc(d));
      if (n > 20) begin
        req[d] = 0;
        @(posedge clk); #1;
        return;
      end
      key = m_key(d, ops[i].addr);
      ee = m_err(ops[i].addr);
      if (ops[i].we || ee) begin
        er = 0; known = 1;
      end else begin
        known = mm.exists(key);
        er = known ? mm[key] : 32'd0;
      end
      if (ops[i].we && !ee) begin
        if (mm.exists(key)) begin
          cur = mm[key];
          for (int k = 0; k < 4; k++)
            if (ops[i].be[k]) cur[8*k +: 8] = ops[i].wdata[8*k +: 8];
          mm[key] = cur;
        end else if (ops[i].be == 4'hF) begin
          mm[key] = ops[i].wdata;
        end
      end
      @(posedge clk); #1;
      chk($sformatf("d%0d_op%0d_rvalid", d, i), rvalid[d], 1);
      if (known) chk($sformatf("d%0d_op%0d_rdata", d, i), rdata[d], er);
      chk($sformatf("d%0d_op%0d_err", d, i), err[d], ee);
    end
    req[d] = 0;
    @(posedge clk); #1;
    chk($sformatf("d%0d_rvalid_drop", d), rvalid[d], 0);
    if (known) chk($sformatf("d%0d_rdata_hold", d), rdata[d], er);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t q[$];
    for (int d = 0; d < 2; d++) begin
      req[d] = 0; we[d] = 0; addr[d] = 0; be[d] = 0; wdata[d] = 0;
    end
    rst_n = 0;
    req[0] = 1;  // zero-wait request during reset must not be granted
    #2;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_gnt%0d", d), gnt[d], 0);
      chk($sformatf("rst_rvalid%0d", d), rvalid[d], 0);
      chk($sformatf("rst_rdata%0d", d), rdata[d], 0);
      chk($sformatf("rst_err%0d", d), err[d], 0);
    end
    req[0] = 0;
    #10 rst_n = 1;
    @(posedge clk); #1;

    // write then read, partial write, empty byte enable
    q = {};
    q.push_back(mk(1, 32'h10, 4'hF, 32'hDEADBEEF));
    q.push_back(mk(0, 32'h10, 4'h0, 32'h0));
    run(0, q);
    q = {};
    q.push_back(mk(1, 32'h10, 4'b0010, 32'h0000_5500));
    q.push_back(mk(0, 32'h10, 4'h0, 32'h0));
    q.push_back(mk(1, 32'h10, 4'b0000, 32'h1111_1111));
    q.push_back(mk(0, 32'h10, 4'h0, 32'h0));
    run(0, q);
    chk("partial_write_value", rdata[0], 32'hDEAD55EF);

    // consecutive accesses at zero wait, read right after write
    q = {};
    for (int i = 0; i < 4; i++) q.push_back(mk(1, 32'(4 * i), 4'hF, 32'hA0 + 32'(i)));
    for (int i = 0; i < 4; i++) q.push_back(mk(0, 32'(4 * i), 4'h0, 32'h0));
    q.push_back(mk(1, 32'h20, 4'hF, 32'h0BADF00D));
    q.push_back(mk(0, 32'h20, 4'h0, 32'h0));
    q.push_back(mk(0, 32'h1000, 4'h0, 32'h0));  // beyond DEPTH
    run(0, q);

    // preload a window on both instances
    for (int d = 0; d < 2; d++) begin
      q = {};
      for (int i = 0; i < 16; i++) q.push_back(mk(1, 32'(4 * i), 4'hF, $urandom | 32'h1));
      run(d, q);
    end

    // withdrawn request on the waiting instance: no grant, no write
    req[1] = 1; we[1] = 1; addr[1] = 32'h24; be[1] = 4'hF; wdata[1] = 32'h12345678;
    @(posedge clk); #1;
    req[1] = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("withdraw_gnt%0d", i), gnt[1], 0);
      chk($sformatf("withdraw_rvalid%0d", i), rvalid[1], 0);
    end
    @(posedge clk); #1;
    q = {};
    q.push_back(mk(0, 32'h24, 4'h0, 32'h0));
    run(1, q);

    // random bursts on both instances
    for (int r = 0; r < 16; r++) begin
      int d;
      int nops;
      logic [31:0] a;
      d = r % 2;
      nops = $urandom_range(1, 4);
      q = {};
      for (int i = 0; i < nops; i++) begin
        a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 255)) * 4096;
        q.push_back(mk(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom));
      end
      run(d, q);
    end

    // reset in the middle of a wait
    q = {};
    q.push_back(mk(0, 32'h4, 4'h0, 32'h0));
    run(1, q);
    req[1] = 1; we[1] = 0; addr[1] = 32'h8;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 0;
    #1;
    chk("midwait_rst_gnt", gnt[1], 0);
    chk("midwait_rst_rvalid", rvalid[1], 0);
    chk("midwait_rst_rdata", rdata[1], 0);
    chk("midwait_rst_err", err[1], 0);
    chk("midwait_rst_rdata0", rdata[0], 0);
    req[1] = 0;
    #3 rst_n = 1;
    @(posedge clk); #1;
    q = {};
    q.push_back(mk(0, 32'h8, 4'h0, 32'h0));
    q.push_back(mk(0, 32'h10, 4'h0, 32'h0));
    run(1, q);
    q = {};
    q.push_back(mk(0, 32'h10, 4'h0, 32'h0));
    run(0, q);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
